// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Optional round-robin policy is selected with DMEM_ARB_RR_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam int NPORTS  = 2;
  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 8;

  typedef struct packed {
    logic               we;
    logic               lock;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the data-memory arbiter.
// DMEM_ARB_RR_EN selects round-robin, otherwise port 0 has fixed priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic              req0,
  input  logic              req1,
  input  arb_state_t        state,
`ifdef DMEM_ARB_RR_EN
  input  logic              rrPtr,
`endif
  output logic [NPORTS-1:0] pick
);

  logic favor1;

  always_comb begin
    pick = '0;
`ifdef DMEM_ARB_RR_EN
    favor1 = rrPtr;
`else
    favor1 = 1'b0;
`endif
    unique case (1'b1)
      state == LOCK0: pick[0] = req0;
      state == LOCK1: pick[1] = req1;
      default: begin
        if (req0 && req1) begin
          pick = favor1 ? 2'b10 : 2'b01;
        end else begin
          pick = {req1, req0};
        end
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the 256x8 data memory, with lockable ownership.
// Define DMEM_ARB_RR_EN for round-robin arbitration of contested cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic          lock0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic          lock1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] DataAddress,
  output logic          ReadMem,
  output logic          WriteMem,
  output logic [DW-1:0] DataIn,
  input  logic [DW-1:0] DataOut
);

  arb_state_t        state;
  arb_state_t        stateNext;
  logic [NPORTS-1:0] pick;
  dmem_req_t         r0;
  dmem_req_t         r1;
  dmem_req_t         sel;
  logic              rd0;
  logic              rd1;

  assign r0 = '{we: we0, lock: lock0, addr: addr0, wdata: wdata0};
  assign r1 = '{we: we1, lock: lock1, addr: addr1, wdata: wdata1};

`ifdef DMEM_ARB_RR_EN
  logic rrPtr;

  // Pointer names the port favoured in the next contested cycle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rrPtr <= 1'b0;
    end else if (state == ARB && req0 && req1) begin
      rrPtr <= gnt0;
    end
  end

  dmem_arb_pick uPick (
    .req0  (req0),
    .req1  (req1),
    .state (state),
    .rrPtr (rrPtr),
    .pick  (pick)
  );
`else
  dmem_arb_pick uPick (
    .req0  (req0),
    .req1  (req1),
    .state (state),
    .pick  (pick)
  );
`endif

  assign gnt0 = pick[0] & ~reset;
  assign gnt1 = pick[1] & ~reset;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= ARB;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (1'b1)
      gnt0:    stateNext = r0.lock ? LOCK0 : ARB;
      gnt1:    stateNext = r1.lock ? LOCK1 : ARB;
      default: stateNext = state;
    endcase
  end

  always_comb begin
    sel         = gnt1 ? r1 : r0;
    DataAddress = '0;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    DataIn      = '0;
    if (gnt0 || gnt1) begin
      DataAddress = sel.addr;
      ReadMem     = ~sel.we;
      WriteMem    = sel.we;
      DataIn      = sel.wdata;
    end
  end

  assign rd0 = gnt0 & ~we0;
  assign rd1 = gnt1 & ~we1;

  // DataOut is only sampled under a read grant, so a floating bus never lands here.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= rd0;
      rvalid1 <= rd1;
      if (rd0) rdata0 <= DataOut;
      if (rd1) rdata1 <= DataOut;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a transaction-level model.
// Build with or without DMEM_ARB_RR_EN; the model follows the same define.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       reset;
  logic       req [2];
  logic       we  [2];
  logic       lock[2];
  logic [7:0] addr [2];
  logic [7:0] wdata[2];

  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] DataAddress, DataIn, DataOut;
  logic       ReadMem, WriteMem;

  logic [7:0] hmem  [256];
  logic [7:0] refMem[256];

  int         nChecks = 0;
  int         nFail   = 0;
  int         owner;
  int         prio;
  int         lastWin;
  logic       expRv[2];
  logic [7:0] expRd[2];
  logic       obsG0, obsG1;

  always #5 CLK = ~CLK;

  dmem_arbiter dut (
    .CLK         (CLK),
    .reset       (reset),
    .req0        (req[0]),
    .we0         (we[0]),
    .lock0       (lock[0]),
    .addr0       (addr[0]),
    .wdata0      (wdata[0]),
    .req1        (req[1]),
    .we1         (we[1]),
    .lock1       (lock[1]),
    .addr1       (addr[1]),
    .wdata1      (wdata[1]),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .rvalid0     (rvalid0),
    .rvalid1     (rvalid1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .DataAddress (DataAddress),
    .ReadMem     (ReadMem),
    .WriteMem    (WriteMem),
    .DataIn      (DataIn),
    .DataOut     (DataOut)
  );

  // Stand-in for data_mem: combinational read, posedge write, floats when idle.
  always_comb DataOut = ReadMem ? hmem[DataAddress] : 8'hzz;

  always @(posedge CLK) begin
    if (WriteMem) hmem[DataAddress] <= DataIn;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setPort(int p, logic r, logic w, logic l,
                         logic [7:0] a, logic [7:0] d);
    req[p]   = r;
    we[p]    = w;
    lock[p]  = l;
    addr[p]  = a;
    wdata[p] = d;
  endtask

  // One clock: inputs already driven at the falling edge.
  task automatic step(string tag);
    int         win;
    bit         contested;
    logic       eRd, eWr;
    logic [7:0] eAddr, eDin;
    #1;
    if (reset) begin
      expRv[0] = 1'b0; expRv[1] = 1'b0;
      expRd[0] = 8'h00; expRd[1] = 8'h00;
    end
    win = -1;
    contested = 1'b0;
    if (!reset) begin
      if (owner >= 0) begin
        win = req[owner] ? owner : -1;
      end else if (req[0] && req[1]) begin
        contested = 1'b1;
        win = RR ? prio : 0;
      end else if (req[0]) begin
        win = 0;
      end else if (req[1]) begin
        win = 1;
      end
    end
    eRd = 1'b0; eWr = 1'b0; eAddr = 8'h00; eDin = 8'h00;
    if (win >= 0) begin
      eRd = ~we[win]; eWr = we[win];
      eAddr = addr[win]; eDin = wdata[win];
    end
    obsG0 = gnt0;
    obsG1 = gnt1;
    lastWin = win;
    check({tag, ".gnt0"}, 32'(gnt0), 32'(win == 0));
    check({tag, ".gnt1"}, 32'(gnt1), 32'(win == 1));
    check({tag, ".rdmem"}, 32'(ReadMem), 32'(eRd));
    check({tag, ".wrmem"}, 32'(WriteMem), 32'(eWr));
    check({tag, ".addr"}, 32'(DataAddress), 32'(eAddr));
    check({tag, ".din"}, 32'(DataIn), 32'(eDin));
    check({tag, ".rv0"}, 32'(rvalid0), 32'(expRv[0]));
    check({tag, ".rv1"}, 32'(rvalid1), 32'(expRv[1]));
    check({tag, ".rd0"}, 32'(rdata0), 32'(expRd[0]));
    check({tag, ".rd1"}, 32'(rdata1), 32'(expRd[1]));
    check({tag, ".x"}, 32'($isunknown({rdata0, rdata1})), 32'd0);
    expRv[0] = 1'b0;
    expRv[1] = 1'b0;
    if (reset) begin
      owner = -1;
      prio  = 0;
    end else if (win >= 0) begin
      if (we[win]) begin
        refMem[addr[win]] = wdata[win];
      end else begin
        expRv[win] = 1'b1;
        expRd[win] = refMem[addr[win]];
      end
      if (contested) prio = 1 - win;
      owner = lock[win] ? win : -1;
    end
    @(negedge CLK);
  endtask

  task automatic idle();
    setPort(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    setPort(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic newTxn(int p);
    logic [7:0] a;
    a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
    setPort(p, $urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 4) == 0,
            a, 8'($urandom));
  endtask

  initial begin
    logic [7:0] v;
    reset = 1'b1;
    idle();
    owner = -1;
    prio  = 0;
    expRv[0] = 1'b0; expRv[1] = 1'b0;
    expRd[0] = 8'h00; expRd[1] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      hmem[i]   = v;
      refMem[i] = v;
    end
    @(negedge CLK);
    step("reset");
    reset = 1'b0;

    // write then read back on port 0
    setPort(0, 1'b1, 1'b1, 1'b0, 8'h10, 8'hA5);
    step("wr10");
    check("wr10.g0", 32'(obsG0), 32'd1);
    setPort(0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    step("rd10");
    check("rd10.g0", 32'(obsG0), 32'd1);
    idle();
    check("rd10.rv0", 32'(rvalid0), 32'd1);
    check("rd10.data", 32'(rdata0), 32'hA5);
    check("rd10.rv1", 32'(rvalid1), 32'd0);
    step("rd10v");

    // contested reads
    setPort(0, 1'b1, 1'b0, 1'b0, 8'h21, 8'h00);
    setPort(1, 1'b1, 1'b0, 1'b0, 8'h22, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step("both");
      check("both.g0", 32'(obsG0), RR ? 32'(i % 2 == 0) : 32'd1);
      check("both.g1", 32'(obsG1), RR ? 32'(i % 2 == 1) : 32'd0);
    end
    idle();
    step("both_end");

    // port 1 locked read-modify-write
    setPort(1, 1'b1, 1'b0, 1'b1, 8'hF4, 8'h00);
    step("lk_rd");
    check("lk_rd.g1", 32'(obsG1), 32'd1);
    setPort(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    setPort(0, 1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
    step("lk_idle");
    check("lk_idle.g0", 32'(obsG0), 32'd0);
    setPort(1, 1'b1, 1'b0, 1'b1, 8'hF4, 8'h00);
    step("lk_rd2");
    check("lk_rd2.g0", 32'(obsG0), 32'd0);
    check("lk_rd2.g1", 32'(obsG1), 32'd1);
    setPort(1, 1'b1, 1'b1, 1'b0, 8'hF4, 8'hF4);
    step("lk_wr");
    check("lk_wr.g0", 32'(obsG0), 32'd0);
    check("lk_wr.g1", 32'(obsG1), 32'd1);
    setPort(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step("lk_rel");
    check("lk_rel.g0", 32'(obsG0), 32'd1);
    idle();
    step("lk_end");

    // reset while locked with a read return pending
    setPort(1, 1'b1, 1'b0, 1'b1, 8'h40, 8'h00);
    step("rs_lk");
    check("rs_lk.g1", 32'(obsG1), 32'd1);
    setPort(1, 1'b1, 1'b1, 1'b1, 8'h40, 8'h77);
    setPort(0, 1'b1, 1'b0, 1'b0, 8'h41, 8'h00);
    reset = 1'b1;
    step("rs_mid");
    check("rs_mid.rv1", 32'(rvalid1), 32'd0);
    check("rs_mid.g0", 32'(obsG0), 32'd0);
    reset = 1'b0;
    setPort(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step("rs_post");
    check("rs_post.g0", 32'(obsG0), 32'd1);
    idle();

    // idle bus: DataOut floats, read data must hold
    for (int i = 0; i < 3; i++) step("zidle");
    check("zidle.rd0", 32'(rdata0), 32'(expRd[0]));

    // top of the address space
    setPort(0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);
    step("ff_wr");
    setPort(0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00);
    step("ff_rd");
    idle();
    check("ff.rd0", 32'(rdata0), 32'hFF);
    step("ff_end");

    // randomized traffic with occasional resets
    newTxn(0);
    newTxn(1);
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      step("rand");
      for (int p = 0; p < 2; p++) begin
        if (!req[p] || lastWin == p) newTxn(p);
      end
    end
    reset = 1'b0;
    idle();
    step("final");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
